sysmon_poller: RTL

- Parametrised successor to the single-address SysMon reader.
- Autonomously round-robin polls NUM_CH SysMon DRP addresses with single-cycle DEN pulses and a DRDY timeout.
- Averages 2^AVG_LOG2 samples per channel, holds per-channel results with valid and high-threshold alarm flags.
- Sits between the SysMon primitive wrapper and PUF/monitoring logic; DRP write path is tied off (DWE=0, DI=0 in the wrapper).

---
 rtl/sysmon_poller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sysmon_poller.sv
// sysmon_poller: round-robin SysMon DRP reader.
// Polls NUM_CH DRP addresses with one-cycle DEN pulses, guards each read with
// a DRDY timeout, averages 2^AVG_LOG2 samples per channel and holds the
// committed averages together with sticky valid flags and high-threshold alarms.
module sysmon_poller #(
   parameter int                  NUM_CH      = 4,
   parameter logic [7*NUM_CH-1:0] ADDR_LIST   = {7'h03, 7'h02, 7'h01, 7'h00},
   parameter int                  AVG_LOG2    = 2,
   parameter int                  TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [6:0]        drp_daddr,
   output logic              drp_den,
   input  logic              drp_drdy,
   input  logic [15:0]       drp_do,
   input  logic [15:0]       thresh_hi,
   input  logic [2:0]        sel_ch,
   output logic [15:0]       rd_data,
   output logic [NUM_CH-1:0] ch_valid,
   output logic [NUM_CH-1:0] alarm,
   output logic              round_done,
   output logic              timeout_err,
   output logic              busy
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int RW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int AW = 16 + AVG_LOG2;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CW-1:0] LAST_CH    = CW'(NUM_CH - 1);
   localparam logic [RW-1:0] LAST_ROUND = RW'((1 << AVG_LOG2) - 1);
   localparam logic [TW-1:0] LAST_WAIT  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACCUM
   } state_t;

   state_t            state_q,     state_d;
   logic [CW-1:0]     ch_q,        ch_d;
   logic [RW-1:0]     roundCnt_q,  roundCnt_d;
   logic [TW-1:0]     waitCnt_q,   waitCnt_d;
   logic [15:0]       sample_q,    sample_d;
   logic              sampleOk_q,  sampleOk_d;
   logic [6:0]        daddr_q,     daddr_d;
   logic [AW-1:0]     acc_q    [NUM_CH];
   logic [AW-1:0]     acc_d    [NUM_CH];
   logic [15:0]       result_q [NUM_CH];
   logic [15:0]       result_d [NUM_CH];
   logic [NUM_CH-1:0] valid_q,     valid_d;
   logic [NUM_CH-1:0] alarm_q,     alarm_d;
   logic [NUM_CH-1:0] bad_q,       bad_d;
   logic              roundDone_q, roundDone_d;
   logic              timeoutErr_q, timeoutErr_d;

   logic [6:0]        issueAddr;
   logic [AW-1:0]     accNew;
   logic [15:0]       resNew;
   logic              commit;
   logic [RW-1:0]     nextRound;

   // Address of the channel currently being polled, plus the running sum and
   // truncated average that the ACCUM cycle would produce for it.
   always_comb begin
      issueAddr = ADDR_LIST[7*int'(ch_q) +: 7];
      accNew    = acc_q[ch_q] + (sampleOk_q ? AW'(sample_q) : AW'(0));
      resNew    = 16'(accNew >> AVG_LOG2);
      commit    = (roundCnt_q == LAST_ROUND);
      nextRound = (AVG_LOG2 == 0) ? RW'(0) : roundCnt_q + RW'(1);
   end

   // Next-state and datapath update for the polling FSM.
   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      roundCnt_d   = roundCnt_q;
      waitCnt_d    = waitCnt_q;
      sample_d     = sample_q;
      sampleOk_d   = sampleOk_q;
      daddr_d      = daddr_q;
      acc_d        = acc_q;
      result_d     = result_q;
      valid_d      = valid_q;
      alarm_d      = alarm_q;
      bad_d        = bad_q;
      roundDone_d  = 1'b0;
      timeoutErr_d = timeoutErr_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            daddr_d    = issueAddr;
            waitCnt_d  = '0;
            sampleOk_d = 1'b0;
            state_d    = WAIT;
         end
         WAIT: begin
            if (drp_drdy) begin
               sample_d   = drp_do;
               sampleOk_d = 1'b1;
               state_d    = ACCUM;
            end else if (waitCnt_q == LAST_WAIT) begin
               bad_d[ch_q]  = 1'b1;
               timeoutErr_d = 1'b1;
               sampleOk_d   = 1'b0;
               state_d      = ACCUM;
            end else begin
               waitCnt_d = waitCnt_q + TW'(1);
            end
         end
         ACCUM: begin
            if (commit) begin
               if (!bad_q[ch_q]) begin
                  result_d[ch_q] = resNew;
                  valid_d[ch_q]  = 1'b1;
                  alarm_d[ch_q]  = (resNew >= thresh_hi);
               end
               acc_d[ch_q] = '0;
               bad_d[ch_q] = 1'b0;
               if (ch_q == LAST_CH) begin
                  roundDone_d = 1'b1;
               end
            end else begin
               acc_d[ch_q] = accNew;
            end
            if (ch_q == LAST_CH) begin
               ch_d       = '0;
               roundCnt_d = nextRound;
            end else begin
               ch_d = ch_q + CW'(1);
            end
            state_d = enable ? ISSUE : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset of every piece of poller state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ch_q         <= '0;
         roundCnt_q   <= '0;
         waitCnt_q    <= '0;
         sample_q     <= '0;
         sampleOk_q   <= 1'b0;
         daddr_q      <= '0;
         valid_q      <= '0;
         alarm_q      <= '0;
         bad_q        <= '0;
         roundDone_q  <= 1'b0;
         timeoutErr_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i]    <= '0;
            result_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         roundCnt_q   <= roundCnt_d;
         waitCnt_q    <= waitCnt_d;
         sample_q     <= sample_d;
         sampleOk_q   <= sampleOk_d;
         daddr_q      <= daddr_d;
         acc_q        <= acc_d;
         result_q     <= result_d;
         valid_q      <= valid_d;
         alarm_q      <= alarm_d;
         bad_q        <= bad_d;
         roundDone_q  <= roundDone_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   // Result readout mux; selects beyond the channel count read as zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_ch == 3'(i)) begin
            rd_data = result_q[i];
         end
      end
   end

   // DEN is high only in ISSUE; the address is presented in ISSUE and held after.
   always_comb begin
      drp_den     = (state_q == ISSUE);
      drp_daddr   = (state_q == ISSUE) ? issueAddr : daddr_q;
      ch_valid    = valid_q;
      alarm       = alarm_q;
      round_done  = roundDone_q;
      timeout_err = timeoutErr_q;
      busy        = (state_q != IDLE);
   end

endmodule
